// File: rtl/cdc_pkg.sv
// Shared helpers for the async-FIFO companion blocks.
package cdc_pkg;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  // A lane counter needs at least one bit even when RATIO is 2.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/cdc_fifo_rd_packer.sv
// Read-domain packer: pops FWFT FIFO words and packs RATIO of them per output beat,
// with flush-driven partial beats qualified by a lane keep mask.
module cdc_fifo_rd_packer
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                     clk_rd,
  input  logic                     arst_rd_n,
  input  logic [WIDTH-1:0]         rd_data_i,
  input  logic                     rd_empty_i,
  output logic                     rd_en_o,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RATIO*WIDTH-1:0]   out_data_o,
  output logic [RATIO-1:0]         out_keep_o,
  output logic                     busy_o
);

  localparam int unsigned CNT_W = cnt_width(RATIO);
  typedef logic [CNT_W-1:0] lane_cnt_t;
  localparam lane_cnt_t LAST_LANE = lane_cnt_t'(RATIO - 1);

  logic                              run_q;
  lane_cnt_t                         cnt_q, cnt_d, cnt_post;
  logic                              flush_pend_q, flush_pend_d;
  logic [RATIO-2:0][WIDTH-1:0]       pack_q, pack_d;
  logic                              out_valid_q, out_valid_d;
  logic [RATIO*WIDTH-1:0]            out_data_q, out_data_d;
  logic [RATIO-1:0]                  out_keep_q, out_keep_d;
  logic                              out_free, pop, load_full, load_part;

  always_comb begin
    out_free  = !out_valid_q || out_ready_i;
    pop       = run_q && !rd_empty_i && !flush_pend_q && ((cnt_q != LAST_LANE) || out_free);
    load_full = pop && (cnt_q == LAST_LANE);
    load_part = flush_pend_q && out_free;

    pack_d   = pack_q;
    cnt_post = cnt_q;
    if (pop) begin
      if (load_full) begin
        cnt_post = '0;
      end else begin
        pack_d[cnt_q] = rd_data_i;
        cnt_post      = cnt_q + 1'b1;
      end
    end

    cnt_d = load_part ? '0 : cnt_post;
    // A flush that finds nothing left after this cycle's pop is dropped, so a flush
    // coinciding with the last-lane pop never produces an empty beat.
    flush_pend_d = flush_pend_q ? !out_free : (flush_i && (cnt_post != '0));

    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    if (load_full) begin
      out_valid_d = 1'b1;
      out_data_d  = {rd_data_i, pack_q};
      out_keep_d  = '1;
    end else if (load_part) begin
      out_valid_d = 1'b1;
      out_data_d  = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
        out_keep_d[i] = lane_cnt_t'(i) < cnt_q;
      end
      // Lanes above cnt may hold stale words from an earlier beat; zero them.
      for (int unsigned i = 0; i < RATIO - 1; i++) begin
        if (lane_cnt_t'(i) < cnt_q) out_data_d[i*WIDTH +: WIDTH] = pack_q[i];
      end
    end
  end

  always_ff @(posedge clk_rd or negedge arst_rd_n) begin
    if (!arst_rd_n) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      pack_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      pack_q       <= pack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end

  assign rd_en_o     = pop;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign busy_o      = (cnt_q != '0) || out_valid_q || flush_pend_q;

`ifndef NO_ASSERTIONS
  ratio_legal: assert property (@(posedge clk_rd) is_pow2(RATIO) && (RATIO >= 2));

  pop_nonempty: assert property (@(posedge clk_rd) disable iff (!arst_rd_n)
    rd_en_o |-> !rd_empty_i);

  stall_stable: assert property (@(posedge clk_rd) disable iff (!arst_rd_n)
    (out_valid_o && !out_ready_i) |=> ($stable(out_data_o) && $stable(out_keep_o)));
`endif

endmodule

// File: tb/tb_cdc_fifo_rd_packer.sv
// Directed and randomized checks for cdc_fifo_rd_packer (WIDTH=8, RATIO=4).
module tb_cdc_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rd_data;
  logic        rd_empty;
  logic        rd_en;
  logic        flush;
  logic        out_valid;
  logic        ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        busy;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] nxt_word = 8'h00;

  cdc_fifo_rd_packer #(.WIDTH(8), .RATIO(4)) dut (
    .clk_rd      (clk),
    .arst_rd_n   (rst_n),
    .rd_data_i   (rd_data),
    .rd_empty_i  (rd_empty),
    .rd_en_o     (rd_en),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (ready),
    .out_data_o  (out_data),
    .out_keep_o  (out_keep),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %0s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    rd_data  = d;
    rd_empty = 1'b0;
    tick();
  endtask

  // One randomized cycle: drive, sample before the edge, score after it.
  task automatic rnd_cycle(input logic e, input logic r, input logic f);
    logic        pop, acc;
    logic [31:0] d, exp_d;
    logic [3:0]  k;
    int unsigned underflow;
    rd_empty = e;
    ready    = r;
    flush    = f;
    rd_data  = nxt_word;
    #1;
    pop = rd_en;
    acc = out_valid && ready;
    d   = out_data;
    k   = out_keep;
    @(posedge clk);
    if (acc) begin
      chk("rnd_keep_contig", {63'd0, (k != 4'd0) && ((k & (k + 4'd1)) == 4'd0)}, 64'd1);
      exp_d     = '0;
      underflow = 0;
      for (int i = 0; i < 4; i++) begin
        if (k[i]) begin
          if (exp_q.size() == 0) underflow++;
          else exp_d[i*8 +: 8] = exp_q.pop_front();
        end
      end
      chk("rnd_underflow", 64'(underflow), 64'd0);
      chk("rnd_data", {32'd0, d}, {32'd0, exp_d});
    end
    if (pop) begin
      exp_q.push_back(nxt_word);
      nxt_word = nxt_word + 8'd1;
    end
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_empty = 1'b0;
    rd_data  = 8'h11;
    flush    = 1'b0;
    ready    = 1'b1;

    // Reset with a non-empty FIFO
    tick(); tick(); tick();
    chk("rst_rd_en",  {63'd0, rd_en},     64'd0);
    chk("rst_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_data",   {32'd0, out_data},  64'd0);
    chk("rst_keep",   {60'd0, out_keep},  64'd0);
    chk("rst_busy",   {63'd0, busy},      64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_first_rd_en", {63'd0, rd_en}, 64'd0);
    tick();
    chk("rel_second_rd_en", {63'd0, rd_en}, 64'd1);

    // Streaming with ready high
    feed(8'h11); feed(8'h22); feed(8'h33);
    rd_data = 8'h44;
    #1;
    chk("strm_rd_en_last", {63'd0, rd_en},     64'd1);
    chk("strm_pre_valid",  {63'd0, out_valid}, 64'd0);
    tick();
    chk("strm_valid", {63'd0, out_valid}, 64'd1);
    chk("strm_data",  {32'd0, out_data},  64'h44332211);
    chk("strm_keep",  {60'd0, out_keep},  64'hf);
    feed(8'h55);
    chk("strm_handoff_valid", {63'd0, out_valid}, 64'd0);
    feed(8'h66); feed(8'h77); feed(8'h88);
    chk("strm2_valid", {63'd0, out_valid}, 64'd1);
    chk("strm2_data",  {32'd0, out_data},  64'h88776655);
    rd_empty = 1'b1;
    tick();
    chk("strm_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("strm_drain_busy",  {63'd0, busy},      64'd0);

    // Backpressure
    ready = 1'b0;
    feed(8'hb0); feed(8'hb1); feed(8'hb2); feed(8'hb3);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_data",  {32'd0, out_data},  64'hb3b2b1b0);
    feed(8'hb4); feed(8'hb5); feed(8'hb6);
    rd_data = 8'hb7;
    #1;
    chk("bp_blocked_rd_en", {63'd0, rd_en}, 64'd0);
    chk("bp_busy",          {63'd0, busy},  64'd1);
    tick(); tick();
    chk("bp_hold_valid",    {63'd0, out_valid}, 64'd1);
    chk("bp_hold_data",     {32'd0, out_data},  64'hb3b2b1b0);
    chk("bp_hold_keep",     {60'd0, out_keep},  64'hf);
    chk("bp_hold_rd_en",    {63'd0, rd_en},     64'd0);
    ready = 1'b1;
    #1;
    chk("bp_release_rd_en", {63'd0, rd_en}, 64'd1);
    tick();
    chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_next_data",  {32'd0, out_data},  64'hb7b6b5b4);
    rd_empty = 1'b1;
    tick();
    chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // Flush of a two-lane partial
    feed(8'haa); feed(8'hbb);
    rd_empty = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    rd_empty = 1'b0;
    rd_data  = 8'hcc;
    #1;
    chk("fl_pend_rd_en", {63'd0, rd_en}, 64'd0);
    chk("fl_pend_busy",  {63'd0, busy},  64'd1);
    tick();
    chk("fl_valid", {63'd0, out_valid}, 64'd1);
    chk("fl_data",  {32'd0, out_data},  64'h0000bbaa);
    chk("fl_keep",  {60'd0, out_keep},  64'h3);
    rd_empty = 1'b1;
    tick();
    chk("fl_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_drain_busy",  {63'd0, busy},      64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_cnt0_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("fl_cnt0_valid", {63'd0, out_valid}, 64'd0);

    // Flush colliding with the last-lane pop
    feed(8'hd1); feed(8'hd2); feed(8'hd3);
    rd_data = 8'hd4;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    rd_empty = 1'b1;
    chk("col_full_valid", {63'd0, out_valid}, 64'd1);
    chk("col_full_data",  {32'd0, out_data},  64'hd4d3d2d1);
    chk("col_full_keep",  {60'd0, out_keep},  64'hf);
    tick();
    chk("col_no_pend_busy", {63'd0, busy},      64'd0);
    chk("col_accept_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("col_no_empty_beat", {63'd0, out_valid}, 64'd0);

    // Flush colliding with the second-lane pop
    feed(8'he1);
    rd_data = 8'he2;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    rd_empty = 1'b1;
    #1;
    chk("col2_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("col2_valid", {63'd0, out_valid}, 64'd1);
    chk("col2_data",  {32'd0, out_data},  64'h0000e2e1);
    chk("col2_keep",  {60'd0, out_keep},  64'h3);
    tick();
    chk("col2_drain_valid", {63'd0, out_valid}, 64'd0);

    // Randomized empty/ready/flush against a word-order scoreboard
    for (int c = 0; c < 10000; c++) begin
      rnd_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    for (int c = 0; c < 3; c++) rnd_cycle(1'b1, 1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b1, 1'b1, 1'b0);
    chk("rnd_all_words_out", 64'(exp_q.size()), 64'd0);
    chk("rnd_final_busy",    {63'd0, busy},     64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
